// File: rtl/rv32i_control_fsm_pkg.sv
// Shared RV32I types: opcodes, funct3 groups, ALU ops, datapath mux selects
// and the control FSM state encoding (exported so benches can see state_dbg).
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // aluop equals funct3 for the plain arithmetic cases; sra/sub occupy the
  // slt/sltu codes because those two go through the comparator instead.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3;

  typedef enum logic [2:0] {
    ld_lb  = 3'b000,
    ld_lh  = 3'b001,
    ld_lw  = 3'b010,
    ld_lbu = 3'b100,
    ld_lhu = 3'b101
  } load_funct3;

  typedef enum logic [2:0] {
    st_sb = 3'b000,
    st_sh = 3'b001,
    st_sw = 3'b010
  } store_funct3;

  typedef enum logic [1:0] {
    pcmux_pc_plus4 = 2'b00,
    pcmux_alu_out  = 2'b01,
    pcmux_alu_mod2 = 2'b10
  } pcmux_sel_t;

  typedef enum logic {
    marmux_pc_out  = 1'b0,
    marmux_alu_out = 1'b1
  } marmux_sel_t;

  typedef enum logic {
    cmpmux_rs2_out = 1'b0,
    cmpmux_i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic {
    alumux1_rs1_out = 1'b0,
    alumux1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm   = 3'd0,
    alumux2_u_imm   = 3'd1,
    alumux2_b_imm   = 3'd2,
    alumux2_s_imm   = 3'd3,
    alumux2_j_imm   = 3'd4,
    alumux2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    rfmux_alu_out  = 4'd0,
    rfmux_br_en    = 4'd1,
    rfmux_u_imm    = 4'd2,
    rfmux_lw       = 4'd3,
    rfmux_pc_plus4 = 4'd4,
    rfmux_lb       = 4'd5,
    rfmux_lbu      = 4'd6,
    rfmux_lh       = 4'd7,
    rfmux_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [3:0] {
    s_fetch1, s_fetch2, s_fetch3, s_decode,
    s_lui, s_auipc, s_jal, s_jalr, s_br, s_imm, s_reg,
    s_calc_addr, s_ld1, s_ld2, s_st1, s_st2
  } state_t;

endpackage

// File: rtl/rv32i_control_fsm_store_mask.sv
// Combinational store byte-enable generator: sb/sh/sw strobes from funct3
// and the byte offset of the store address.
module rv32i_store_mask
  import rv32i_types::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] mar_lsb,
  output logic [3:0] byte_enable
);

  always_comb begin
    byte_enable = 4'b1111;
    case (funct3)
      st_sb:   byte_enable = 4'b0001 << mar_lsb;
      st_sh:   byte_enable = 4'b0011 << {mar_lsb[1], 1'b0};
      default: byte_enable = 4'b1111;
    endcase
  end

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle RV32I control unit: Moore decode of state plus IR fields.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module rv32i_control_fsm
  import rv32i_types::*;
#(
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic [6:0]                funct7,
  input  logic                      br_en,
  input  logic [1:0]                mar_lsb,
  input  logic                      mem_resp,
  output logic                      load_pc,
  output logic                      load_ir,
  output logic                      load_regfile,
  output logic                      load_mar,
  output logic                      load_mdr,
  output logic                      load_data_out,
  output logic [1:0]                pcmux_sel,
  output logic                      marmux_sel,
  output logic                      cmpmux_sel,
  output logic                      alumux1_sel,
  output logic [2:0]                alumux2_sel,
  output logic [3:0]                regfilemux_sel,
  output logic [2:0]                aluop,
  output logic [2:0]                cmpop,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [3:0]                mem_byte_enable,
  output logic                      illegal_instr,
`ifdef CTRL_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] cycle_cnt,
  output logic [PERF_CNT_WIDTH-1:0] instret_cnt,
`endif
  output state_t                    state_dbg
);

  // Memory handshake: mem_read/mem_write rise on entry to a memory state and
  // stay high every cycle until a cycle with mem_resp=1, after which the FSM
  // leaves the state on that edge; mem_resp in any other state is ignored.

  state_t     state, state_next;
  logic [3:0] store_be;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign state_dbg     = state;

  if (PERF_CNT_WIDTH < 1) begin : g_perf_width_check
    $error("PERF_CNT_WIDTH must be at least 1");
  end

  rv32i_store_mask u_store_mask (
    .funct3      (funct3),
    .mar_lsb     (mar_lsb),
    .byte_enable (store_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= s_fetch1;
    else        state <= state_next;
  end

  // Outputs are gated by rst_n so a reset mid-access drops requests at once.
  always_comb begin
    state_next      = state;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = pcmux_pc_plus4;
    marmux_sel      = marmux_pc_out;
    cmpmux_sel      = cmpmux_rs2_out;
    alumux1_sel     = alumux1_rs1_out;
    alumux2_sel     = alumux2_i_imm;
    regfilemux_sel  = rfmux_alu_out;
    aluop           = alu_add;
    cmpop           = beq;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    illegal_instr   = 1'b0;

    if (rst_n) begin
      case (state)
        s_fetch1: begin
          marmux_sel = marmux_pc_out;
          load_mar   = 1'b1;
          state_next = s_fetch2;
        end
        s_fetch2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) state_next = s_fetch3;
        end
        s_fetch3: begin
          load_ir    = 1'b1;
          state_next = s_decode;
        end
        s_decode: begin
          case (opcode)
            op_lui:   state_next = s_lui;
            op_auipc: state_next = s_auipc;
            op_jal:   state_next = s_jal;
            op_jalr:  state_next = s_jalr;
            op_br:    state_next = s_br;
            op_imm:   state_next = s_imm;
            op_reg:   state_next = s_reg;
            op_load,
            op_store: state_next = s_calc_addr;
            default: begin
              illegal_instr = 1'b1;
              state_next    = s_fetch1;
            end
          endcase
        end
        s_lui: begin
          regfilemux_sel = rfmux_u_imm;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
          state_next     = s_fetch1;
        end
        s_auipc: begin
          alumux1_sel    = alumux1_pc_out;
          alumux2_sel    = alumux2_u_imm;
          aluop          = alu_add;
          regfilemux_sel = rfmux_alu_out;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
          state_next     = s_fetch1;
        end
        s_jal: begin
          regfilemux_sel = rfmux_pc_plus4;
          load_regfile   = 1'b1;
          alumux1_sel    = alumux1_pc_out;
          alumux2_sel    = alumux2_j_imm;
          pcmux_sel      = pcmux_alu_out;
          load_pc        = 1'b1;
          state_next     = s_fetch1;
        end
        s_jalr: begin
          regfilemux_sel = rfmux_pc_plus4;
          load_regfile   = 1'b1;
          alumux1_sel    = alumux1_rs1_out;
          alumux2_sel    = alumux2_i_imm;
          pcmux_sel      = pcmux_alu_mod2;
          load_pc        = 1'b1;
          state_next     = s_fetch1;
        end
        s_br: begin
          cmpmux_sel  = cmpmux_rs2_out;
          cmpop       = funct3;
          alumux1_sel = alumux1_pc_out;
          alumux2_sel = alumux2_b_imm;
          pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
          load_pc     = 1'b1;
          state_next  = s_fetch1;
        end
        s_imm: begin
          alumux2_sel  = alumux2_i_imm;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = s_fetch1;
          if (funct3 == f3_slt || funct3 == f3_sltu) begin
            cmpmux_sel     = cmpmux_i_imm;
            cmpop          = (funct3 == f3_slt) ? blt : bltu;
            regfilemux_sel = rfmux_br_en;
          end else if (funct3 == f3_sr && funct7[5]) begin
            aluop = alu_sra;
          end else begin
            aluop = funct3;
          end
        end
        s_reg: begin
          alumux2_sel  = alumux2_rs2_out;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = s_fetch1;
          if (funct3 == f3_slt || funct3 == f3_sltu) begin
            cmpmux_sel     = cmpmux_rs2_out;
            cmpop          = (funct3 == f3_slt) ? blt : bltu;
            regfilemux_sel = rfmux_br_en;
          end else if (funct3 == f3_add && funct7[5]) begin
            aluop = alu_sub;
          end else if (funct3 == f3_sr && funct7[5]) begin
            aluop = alu_sra;
          end else begin
            aluop = funct3;
          end
        end
        s_calc_addr: begin
          aluop      = alu_add;
          marmux_sel = marmux_alu_out;
          load_mar   = 1'b1;
          if (opcode == op_store) begin
            alumux2_sel   = alumux2_s_imm;
            load_data_out = 1'b1;
            state_next    = s_st1;
          end else begin
            alumux2_sel = alumux2_i_imm;
            state_next  = s_ld1;
          end
        end
        s_ld1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) state_next = s_ld2;
        end
        s_ld2: begin
          case (funct3)
            ld_lb:   regfilemux_sel = rfmux_lb;
            ld_lh:   regfilemux_sel = rfmux_lh;
            ld_lbu:  regfilemux_sel = rfmux_lbu;
            ld_lhu:  regfilemux_sel = rfmux_lhu;
            default: regfilemux_sel = rfmux_lw;
          endcase
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = s_fetch1;
        end
        s_st1: begin
          mem_write       = 1'b1;
          mem_byte_enable = store_be;
          if (mem_resp) state_next = s_st2;
        end
        s_st2: begin
          load_pc    = 1'b1;
          state_next = s_fetch1;
        end
        default: state_next = s_fetch1;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Both counters wrap naturally at 2^PERF_CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + PERF_CNT_WIDTH'(1);
      if (load_pc) instret_cnt <= instret_cnt + PERF_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Bench for rv32i_control_fsm: directed cases then random instructions,
// checked per retirement against an ISA-level expectation model.
module tb_rv32i_control_fsm;
  import rv32i_types::*;

  localparam int PW = 32;
  localparam int EW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       br_en = 1'b0;
  logic [1:0] mar_lsb = '0;
  logic       mem_resp = 1'b0;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0] pcmux_sel;
  logic       marmux_sel, cmpmux_sel, alumux1_sel;
  logic [2:0] alumux2_sel;
  logic [3:0] regfilemux_sel;
  logic [2:0] aluop, cmpop;
  logic       mem_read, mem_write;
  logic [3:0] mem_byte_enable;
  logic       illegal_instr;
  state_t     state_dbg;
`ifdef CTRL_PERF_CNT_EN
  logic [PW-1:0] cycle_cnt, instret_cnt;
  logic [PW-1:0] cyc_ref;
`endif

  // clock / reset
  always #5 clk = ~clk;

  rv32i_control_fsm #(.PERF_CNT_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .cmpop(cmpop),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .illegal_instr(illegal_instr),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state_dbg(state_dbg)
  );

`ifdef CTRL_PERF_CNT_EN
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc_ref <= '0;
    else        cyc_ref <= cyc_ref + PW'(1);
`endif

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [7:0]    calc_q[$];
  logic [3:0]    be_q[$];
  int            dly_q[$];
  int n_cmp = 0, n_bad = 0;
  int n_ret = 0, n_pc = 0;
  int cyc = 0, ir_cnt = 0, rf_cnt = 0;
  logic prev_write = 1'b0;
  logic hold_mem = 1'b1;
  int acc_cnt = 0, acc_dly = 1;
  logic in_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  // Byte lanes covered by an access of the store's size at its aligned base.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lsb);
    int size, base;
    logic [3:0] be;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    base = int'(lsb) - (int'(lsb) % size);
    be = '0;
    for (int k = 0; k < size; k++) be[base + k] = 1'b1;
    return be;
  endfunction

  // Expected retire-cycle outputs and cycle count per instruction.
  function automatic logic [EW-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic br,
                                          input int df, input int dd);
    logic ill, lpc, lrf, am1, cmx;
    logic [1:0] pcm;
    logic [2:0] am2, aop, cop;
    logic [3:0] rfm;
    int lat;
    ill = 0; lpc = 1; lrf = 1; am1 = 0; cmx = 0; pcm = 0; am2 = 0; aop = 0; cop = 0; rfm = 0;
    lat = 5 + df - 1;
    case (op)
      7'b0110111: rfm = 4'd2;
      7'b0010111: begin am1 = 1; am2 = 3'd1; end
      7'b1101111: begin rfm = 4'd4; am1 = 1; am2 = 3'd4; pcm = 2'd1; end
      7'b1100111: begin rfm = 4'd4; pcm = 2'd2; end
      7'b1100011: begin lrf = 0; am1 = 1; am2 = 3'd2; cop = f3; pcm = br ? 2'd1 : 2'd0; end
      7'b0010011, 7'b0110011: begin
        if (op == 7'b0110011) am2 = 3'd5;
        if (f3 == 3'd2 || f3 == 3'd3) begin
          cmx = (op == 7'b0010011);
          cop = (f3 == 3'd2) ? 3'b100 : 3'b110;
          rfm = 4'd1;
        end else if (f3 == 3'd5 && f7[5]) aop = 3'(alu_sra);
        else if (op == 7'b0110011 && f3 == 3'd0 && f7[5]) aop = 3'(alu_sub);
        else aop = f3;
      end
      7'b0000011: begin
        lat = lat + 2 + dd - 1;
        case (f3)
          3'd0: rfm = 4'd5;
          3'd1: rfm = 4'd7;
          3'd4: rfm = 4'd6;
          3'd5: rfm = 4'd8;
          default: rfm = 4'd3;
        endcase
      end
      7'b0100011: begin lrf = 0; lat = lat + 2 + dd - 1; end
      default: begin ill = 1; lpc = 0; lrf = 0; lat = lat - 1; end
    endcase
    return {ill, lpc, lrf, pcm, am1, am2, rfm, aop, cop, cmx, 6'(lat), 2'd1, 1'b0, lrf, 2'b00};
  endfunction

  // memory responder: random latency per access, spurious pulses when idle
  always @(negedge clk) begin
    if (!rst_n || hold_mem) begin
      mem_resp = 1'b0;
      in_acc   = 1'b0;
    end else if (mem_read || mem_write) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        acc_cnt = 0;
        acc_dly = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
      end
      acc_cnt++;
      mem_resp = (acc_cnt == acc_dly);
      if (mem_resp) in_acc = 1'b0;
    end else begin
      mem_resp = ($urandom_range(0, 3) == 0);
      in_acc   = 1'b0;
    end
  end

  // monitor: compare on address calc, first store cycle and retirement
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_mar && !marmux_sel) begin cyc = 1; ir_cnt = 0; rf_cnt = 0; end
      else cyc++;
      ir_cnt += int'(load_ir);
      rf_cnt += int'(load_regfile);
      if (load_mar && marmux_sel) begin
        if (calc_q.size() == 0) check("calc_unexpected", 1, 0);
        else check("calc_addr", {alumux1_sel, alumux2_sel, aluop, load_data_out}, calc_q.pop_front());
      end
      if (mem_write && !prev_write) begin
        if (be_q.size() == 0) check("store_unexpected", 1, 0);
        else check("store_be", {mem_read, mem_byte_enable}, {1'b0, be_q.pop_front()});
      end
      prev_write = mem_write;
      if (load_pc || illegal_instr) begin
        if (exp_q.size() == 0) check("retire_unexpected", 1, 0);
        else check("retire", {illegal_instr, load_pc, load_regfile, pcmux_sel, alumux1_sel,
                              alumux2_sel, regfilemux_sel, aluop, cmpop, cmpmux_sel,
                              6'(cyc), 2'(ir_cnt), 2'(rf_cnt), 2'b00}, exp_q.pop_front());
        n_ret++;
        if (load_pc) n_pc++;
      end
    end
  end

  // driver: queue expectations, present IR fields, wait for retirement
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic br, input logic [1:0] lsb, input int df, input int dd);
    int target;
    exp_q.push_back(model(op, f3, f7, br, df, dd));
    dly_q.push_back(df);
    if (op == 7'b0000011 || op == 7'b0100011) begin
      dly_q.push_back(dd);
      calc_q.push_back((op == 7'b0100011) ? 8'b0_011_000_1 : 8'b0_000_000_0);
    end
    if (op == 7'b0100011) be_q.push_back(store_be(f3, lsb));
    opcode = op; funct3 = f3; funct7 = f7; br_en = br; mar_lsb = lsb;
    target = n_ret + 1;
    for (int i = 0; i < 60 && n_ret < target; i++) @(posedge clk);
    check("retire_timeout", 64'(n_ret >= target), 1);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [2:0] br_f3 [6];
    int k;
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    opcode = 7'b0010011;
    repeat (3) @(posedge clk);
    #1;
    check("reset_loads", {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                          mem_read, mem_write, illegal_instr}, 0);
    check("reset_selects", {pcmux_sel, marmux_sel, cmpmux_sel, alumux1_sel, alumux2_sel,
                            regfilemux_sel, aluop, cmpop}, 0);
    check("reset_byte_enable", mem_byte_enable, 4'b1111);
    rst_n = 1'b1;
    #1 check("fetch1_after_reset", {load_mar, marmux_sel, mem_read}, 3'b100);
`ifdef CTRL_PERF_CNT_EN
    check("cnt_reset", {cycle_cnt, instret_cnt}, 0);
`endif
    @(posedge clk);
    #1 check("fetch2_request", {mem_read, load_mdr, mem_write}, 3'b110);
    #2 rst_n = 1'b0;
    #1 check("async_reset_drop", {mem_read, load_mdr, mem_write, load_mar}, 0);
    check("async_reset_be", mem_byte_enable, 4'b1111);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold_mem = 1'b0;
    n_pc = 0;
    #1 check("fetch1_after_midreset", {load_mar, marmux_sel, mem_read}, 3'b100);
`ifdef CTRL_PERF_CNT_EN
    check("cnt_midreset", {cycle_cnt, instret_cnt}, 0);
`endif

    issue(7'b0010011, 3'b000, 7'h00, 1'b0, 2'b00, 1, 1);  // addi x1,x0,5
    issue(7'b1100011, 3'b000, 7'h00, 1'b1, 2'b00, 1, 1);  // beq taken
    issue(7'b1100011, 3'b000, 7'h00, 1'b0, 2'b00, 1, 1);  // beq not taken
    issue(7'b0000011, 3'b100, 7'h00, 1'b0, 2'b11, 1, 3);  // lbu, slow memory
    issue(7'b0100011, 3'b000, 7'h00, 1'b0, 2'b10, 1, 1);  // sb
    issue(7'b0100011, 3'b001, 7'h00, 1'b0, 2'b10, 2, 2);  // sh
    issue(7'b0100011, 3'b010, 7'h00, 1'b0, 2'b00, 1, 1);  // sw
    issue(7'h00, 3'b000, 7'h00, 1'b0, 2'b00, 1, 1);       // illegal
    issue(7'b0110011, 3'b000, 7'h20, 1'b0, 2'b00, 1, 1);  // sub
    issue(7'b0010011, 3'b101, 7'h20, 1'b0, 2'b00, 1, 1);  // srai

    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 9));
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom_range(0, 127));
      case (k)
        0: op = 7'b0110111;
        1: op = 7'b0010111;
        2: op = 7'b1101111;
        3: op = 7'b1100111;
        4: begin op = 7'b1100011; f3 = br_f3[$urandom_range(0, 5)]; end
        5: op = 7'b0010011;
        6: op = 7'b0110011;
        7: op = 7'b0000011;
        8: begin op = 7'b0100011; f3 = 3'($urandom_range(0, 2)); end
        default: begin
          op = 7'($urandom_range(0, 127));
          while (is_legal(op)) op = 7'($urandom_range(0, 127));
        end
      endcase
      issue(op, f3, f7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    end

    @(negedge clk);
    check("queues_drained", {32'(exp_q.size()), 32'(calc_q.size() + be_q.size())}, 0);
`ifdef CTRL_PERF_CNT_EN
    check("cycle_cnt", cycle_cnt, cyc_ref);
    check("instret_cnt", instret_cnt, PW'(n_pc));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
